clct_es_key_builder: RTL and testbench

Post-lookup stage for the CCLUT pattern finder. Consumes the two best CLCT candidates' key half-strips together with the 4-bit position offset and 5-bit bend from the CCLUT lookup. Produces eighth-strip (ES), quarter-strip (QS) and corrected half-strip keys, and cancels a second CLCT that lands on the same corrected half-strip as the first. Pipelined at full bunch-crossing rate and feeds the CLCT header/readout packer.

---
 rtl/clct_es_key_builder.sv | 157 +++++++++++++++
 tb/tb_clct_es_key_builder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/clct_es_key_builder.sv
// rtl/clct_es_key_builder.sv - CCLUT post-lookup ES/QS/HS key builder with ghost cancel
`timescale 1ns/1ps
module clct_es_key_builder #(
  parameter int MXKEYB  = 8,
  parameter int NHS     = 224,
  parameter int MXOFFSB = 4,
  parameter int MXBNDB  = 5,
  parameter int MXESB   = 10,
  parameter int MXCNTB  = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                valid_in,
  input  logic [MXKEYB-1:0]   hs_key0,
  input  logic [MXKEYB-1:0]   hs_key1,
  input  logic                vld1_in,
  input  logic [MXOFFSB-1:0]  offs0,
  input  logic [MXOFFSB-1:0]  offs1,
  input  logic [MXBNDB-1:0]   bend0,
  input  logic [MXBNDB-1:0]   bend1,
  input  logic                cnt_clr,
  output logic                valid_out,
  output logic [MXESB-1:0]    es_key0,
  output logic [MXESB-1:0]    es_key1,
  output logic [MXESB-2:0]    qs_key0,
  output logic [MXESB-2:0]    qs_key1,
  output logic [MXKEYB-1:0]   hs_corr0,
  output logic [MXKEYB-1:0]   hs_corr1,
  output logic [MXBNDB-1:0]   bend0_out,
  output logic [MXBNDB-1:0]   bend1_out,
  output logic                vld1_out,
  output logic                clamp0,
  output logic                clamp1,
  output logic                ghost_drop,
  output logic [MXCNTB-1:0]   clamp_cnt,
  output logic [MXCNTB-1:0]   ghost_cnt
);

  // Two guard bits so the -5..4*(NHS-1)+10 range is representable as signed.
  localparam int EW = MXESB + 2;
  localparam logic signed [EW-1:0] ES_BIAS = EW'(5);
  localparam logic signed [EW-1:0] ES_MAX  = EW'(4 * NHS - 1);
  localparam logic [MXESB-1:0]     ES_TOP  = MXESB'(4 * NHS - 1);

  logic                v_r, vld1_r;
  logic [MXKEYB-1:0]   hs0_r, hs1_r;
  logic [MXOFFSB-1:0]  offs0_r, offs1_r;
  logic [MXBNDB-1:0]   bend0_r, bend1_r;

  logic [MXESB-1:0]    es0_c, es1_c;
  logic                clamp0_c, clamp1_c;
  logic [MXKEYB-1:0]   hsc0_c, hsc1_c;
  logic                same_hs;
  logic [MXCNTB:0]     clamp_sum, ghost_sum;
  logic [MXCNTB-1:0]   clamp_cnt_nx, ghost_cnt_nx;

  // Returns {clamp, es_key}: offset v is v-7 ES units around the HS centre (+2).
  function automatic logic [MXESB:0] es_calc(input logic [MXKEYB-1:0] hs,
                                             input logic [MXOFFSB-1:0] offs);
    logic signed [EW-1:0] raw;
    raw = $signed({{(EW-MXKEYB-2){1'b0}}, hs, 2'b00})
        + $signed({{(EW-MXOFFSB){1'b0}}, offs}) - ES_BIAS;
    if (raw[EW-1])        es_calc = {1'b1, {MXESB{1'b0}}};
    else if (raw > ES_MAX) es_calc = {1'b1, ES_TOP};
    else                  es_calc = {1'b0, raw[MXESB-1:0]};
  endfunction

  // Stage 1: capture the lookup results.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      v_r     <= 1'b0;
      vld1_r  <= 1'b0;
      hs0_r   <= '0;
      hs1_r   <= '0;
      offs0_r <= '0;
      offs1_r <= '0;
      bend0_r <= '0;
      bend1_r <= '0;
    end else begin
      v_r     <= valid_in;
      vld1_r  <= vld1_in;
      hs0_r   <= hs_key0;
      hs1_r   <= hs_key1;
      offs0_r <= offs0;
      offs1_r <= offs1;
      bend0_r <= bend0;
      bend1_r <= bend1;
    end
  end

  // Key arithmetic and ghost comparison on the corrected (post-clamp) half-strips.
  always_comb begin
    {clamp0_c, es0_c} = es_calc(hs0_r, offs0_r);
    {clamp1_c, es1_c} = es_calc(hs1_r, offs1_r);
    hsc0_c  = MXKEYB'(es0_c >> 2);
    hsc1_c  = MXKEYB'(es1_c >> 2);
    same_hs = (hsc0_c == hsc1_c);
  end

  // Stage 2: register keys and flags; key fields only move on valid events.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_out  <= 1'b0;
      vld1_out   <= 1'b0;
      clamp0     <= 1'b0;
      clamp1     <= 1'b0;
      ghost_drop <= 1'b0;
      es_key0    <= '0;
      es_key1    <= '0;
      qs_key0    <= '0;
      qs_key1    <= '0;
      hs_corr0   <= '0;
      hs_corr1   <= '0;
      bend0_out  <= '0;
      bend1_out  <= '0;
    end else begin
      valid_out  <= v_r;
      vld1_out   <= v_r & vld1_r & ~same_hs;
      clamp0     <= v_r & clamp0_c;
      clamp1     <= v_r & vld1_r & ~same_hs & clamp1_c;
      ghost_drop <= v_r & vld1_r & same_hs;
      if (v_r) begin
        es_key0   <= es0_c;
        es_key1   <= es1_c;
        qs_key0   <= (MXESB-1)'(es0_c >> 1);
        qs_key1   <= (MXESB-1)'(es1_c >> 1);
        hs_corr0  <= hsc0_c;
        hs_corr1  <= hsc1_c;
        bend0_out <= bend0_r;
        bend1_out <= bend1_r;
      end
    end
  end

  // Saturating sums; the extra carry bit flags overflow past all-ones.
  always_comb begin
    clamp_sum    = {1'b0, clamp_cnt} + (MXCNTB+1)'(clamp0) + (MXCNTB+1)'(clamp1);
    ghost_sum    = {1'b0, ghost_cnt} + (MXCNTB+1)'(1);
    clamp_cnt_nx = clamp_sum[MXCNTB] ? {MXCNTB{1'b1}} : clamp_sum[MXCNTB-1:0];
    ghost_cnt_nx = ghost_sum[MXCNTB] ? {MXCNTB{1'b1}} : ghost_sum[MXCNTB-1:0];
  end

  // Diagnostic counters; clear wins over a same-cycle increment.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clamp_cnt <= '0;
      ghost_cnt <= '0;
    end else if (cnt_clr) begin
      clamp_cnt <= '0;
      ghost_cnt <= '0;
    end else begin
      if (valid_out)  clamp_cnt <= clamp_cnt_nx;
      if (ghost_drop) ghost_cnt <= ghost_cnt_nx;
    end
  end

endmodule

// File: tb/tb_clct_es_key_builder.sv
// tb/tb_clct_es_key_builder.sv - directed vector bench for clct_es_key_builder
`timescale 1ns/1ps
module tb_clct_es_key_builder;

  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       valid_in = 1'b0;
  logic [7:0] hs_key0 = '0, hs_key1 = '0;
  logic       vld1_in = 1'b0;
  logic [3:0] offs0 = '0, offs1 = '0;
  logic [4:0] bend0 = '0, bend1 = '0;
  logic       cnt_clr = 1'b0;
  logic       valid_out;
  logic [9:0] es_key0, es_key1;
  logic [8:0] qs_key0, qs_key1;
  logic [7:0] hs_corr0, hs_corr1;
  logic [4:0] bend0_out, bend1_out;
  logic       vld1_out, clamp0, clamp1, ghost_drop;
  logic [CW-1:0] clamp_cnt, ghost_cnt;

  int n_checks = 0;
  int n_err = 0;
  int clamp_exp = 0;
  int ghost_exp = 0;

  clct_es_key_builder #(.MXCNTB(CW)) dut (
    .clock(clock), .reset_n(reset_n), .valid_in(valid_in),
    .hs_key0(hs_key0), .hs_key1(hs_key1), .vld1_in(vld1_in),
    .offs0(offs0), .offs1(offs1), .bend0(bend0), .bend1(bend1),
    .cnt_clr(cnt_clr), .valid_out(valid_out),
    .es_key0(es_key0), .es_key1(es_key1), .qs_key0(qs_key0), .qs_key1(qs_key1),
    .hs_corr0(hs_corr0), .hs_corr1(hs_corr1),
    .bend0_out(bend0_out), .bend1_out(bend1_out),
    .vld1_out(vld1_out), .clamp0(clamp0), .clamp1(clamp1), .ghost_drop(ghost_drop),
    .clamp_cnt(clamp_cnt), .ghost_cnt(ghost_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    int hs0, o0, hs1, o1, vld1, b0, b1;
    int es0, es1, c0, c1, v1o, gh;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(input int hs0, o0, hs1, o1, vld1, b0, b1,
                              input int es0, es1, c0, c1, v1o, gh);
    vec_t v;
    v.hs0 = hs0; v.o0 = o0; v.hs1 = hs1; v.o1 = o1; v.vld1 = vld1;
    v.b0 = b0; v.b1 = b1; v.es0 = es0; v.es1 = es1;
    v.c0 = c0; v.c1 = c1; v.v1o = v1o; v.gh = gh;
    return v;
  endfunction

  function automatic int sat(input int cur, input int inc);
    return (cur + inc > CMAX) ? CMAX : cur + inc;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // One isolated event: one-cycle valid pulse, outputs after T+1, counters after T+2.
  task automatic apply(input vec_t v, input string tag);
    @(negedge clock);
    hs_key0 = 8'(v.hs0); offs0 = 4'(v.o0); bend0 = 5'(v.b0);
    hs_key1 = 8'(v.hs1); offs1 = 4'(v.o1); bend1 = 5'(v.b1);
    vld1_in = v.vld1[0]; valid_in = 1'b1;
    @(negedge clock);
    valid_in = 1'b0; vld1_in = 1'b0;
    @(negedge clock);
    chk({tag, ".valid_out"}, int'(valid_out), 1);
    chk({tag, ".es_key0"},   int'(es_key0),   v.es0);
    chk({tag, ".qs_key0"},   int'(qs_key0),   v.es0 / 2);
    chk({tag, ".hs_corr0"},  int'(hs_corr0),  v.es0 / 4);
    chk({tag, ".es_key1"},   int'(es_key1),   v.es1);
    chk({tag, ".qs_key1"},   int'(qs_key1),   v.es1 / 2);
    chk({tag, ".hs_corr1"},  int'(hs_corr1),  v.es1 / 4);
    chk({tag, ".clamp0"},    int'(clamp0),    v.c0);
    chk({tag, ".clamp1"},    int'(clamp1),    v.c1);
    chk({tag, ".vld1_out"},  int'(vld1_out),  v.v1o);
    chk({tag, ".ghost"},     int'(ghost_drop), v.gh);
    chk({tag, ".bend0_out"}, int'(bend0_out), v.b0);
    chk({tag, ".bend1_out"}, int'(bend1_out), v.b1);
    clamp_exp = sat(clamp_exp, v.c0 + v.c1);
    ghost_exp = sat(ghost_exp, v.gh);
    @(negedge clock);
    chk({tag, ".valid_out_drop"}, int'(valid_out), 0);
    chk({tag, ".clamp_cnt"}, int'(clamp_cnt), clamp_exp);
    chk({tag, ".ghost_cnt"}, int'(ghost_cnt), ghost_exp);
  endtask

  initial begin
    vec_t dc;
    //              hs0 o0 hs1 o1 v1 b0 b1   es0  es1 c0 c1 v1o gh
    vecs[0]  = mk( 10,  7,   0,  0, 0,  3, 17,  42,   0, 0, 0, 0, 0);
    vecs[1]  = mk(  0,  0,   0,  0, 0,  0,  0,   0,   0, 1, 0, 0, 0);
    vecs[2]  = mk(  0,  5,   0,  0, 0,  1,  2,   0,   0, 0, 0, 0, 0);
    vecs[3]  = mk(223, 15, 200, 15, 1, 31, 16, 895, 810, 1, 0, 1, 0);
    vecs[4]  = mk( 20, 11,  21,  3, 1,  5,  6,  86,  82, 0, 0, 1, 0);
    vecs[5]  = mk( 20, 11,  22,  7, 1,  7,  8,  86,  90, 0, 0, 1, 0);
    vecs[6]  = mk( 20, 11,  21,  7, 1,  9, 10,  86,  86, 0, 0, 0, 1);
    vecs[7]  = mk(  0,  0,   0,  2, 1, 11, 12,   0,   0, 1, 0, 0, 1);
    vecs[8]  = mk(  5,  7, 223, 15, 0, 13, 14,  22, 895, 0, 0, 0, 0);
    vecs[9]  = mk(  5,  7,   5,  7, 0, 15, 20,  22,  22, 0, 0, 0, 0);
    vecs[10] = mk(223,  8, 223,  9, 1, 21, 22, 895, 895, 0, 0, 0, 1);
    vecs[11] = mk(  0,  4, 200,  0, 1, 23, 24,   0, 795, 1, 0, 1, 0);
    dc       = mk(  0,  0, 223, 15, 1,  2,  3,   0, 895, 1, 1, 1, 0);

    // Reset state.
    #3;
    chk("rst.valid_out", int'(valid_out), 0);
    chk("rst.es_key0",   int'(es_key0),   0);
    chk("rst.clamp_cnt", int'(clamp_cnt), 0);
    chk("rst.ghost_cnt", int'(ghost_cnt), 0);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 12; i++) apply(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back burst: outputs trail inputs by two cycles.
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      if (i < 4) begin
        hs_key0 = 8'(i + 1); offs0 = 4'd7; vld1_in = 1'b0; valid_in = 1'b1;
      end else begin
        valid_in = 1'b0;
      end
      if (i >= 2 && i < 6) begin
        chk($sformatf("burst%0d.valid_out", i), int'(valid_out), 1);
        chk($sformatf("burst%0d.es_key0", i), int'(es_key0), 4 * (i - 1) + 2);
      end
      if (i == 6) chk("burst.valid_out_end", int'(valid_out), 0);
    end

    // Asynchronous reset mid-burst with counters non-zero.
    chk("pre_rst.clamp_cnt", int'(clamp_cnt), clamp_exp);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      hs_key0 = 8'(i + 1); offs0 = 4'd7; valid_in = 1'b1;
    end
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    valid_in = 1'b0;
    #1;
    chk("arst.valid_out", int'(valid_out), 0);
    chk("arst.es_key0",   int'(es_key0),   0);
    chk("arst.clamp_cnt", int'(clamp_cnt), 0);
    chk("arst.ghost_cnt", int'(ghost_cnt), 0);
    clamp_exp = 0;
    ghost_exp = 0;
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk($sformatf("post_rst%0d.valid_out", i), int'(valid_out), 0);
    end
    apply(vecs[0], "post_rst.vec0");

    // Saturation: double clamps walk 2,4,..,14 then 14+2 sticks at all-ones.
    for (int i = 0; i < 20; i++) apply(dc, $sformatf("sat%0d", i));
    chk("sat.clamp_cnt_final", int'(clamp_cnt), CMAX);

    // Clear coincident with a clamping valid_out cycle.
    @(negedge clock);
    hs_key0 = 8'(dc.hs0); offs0 = 4'(dc.o0); hs_key1 = 8'(dc.hs1); offs1 = 4'(dc.o1);
    vld1_in = 1'b1; valid_in = 1'b1;
    @(negedge clock);
    valid_in = 1'b0; vld1_in = 1'b0;
    @(negedge clock);
    chk("clr.valid_out", int'(valid_out), 1);
    chk("clr.clamp1", int'(clamp1), 1);
    cnt_clr = 1'b1;
    @(negedge clock);
    cnt_clr = 1'b0;
    chk("clr.clamp_cnt", int'(clamp_cnt), 0);
    @(negedge clock);
    chk("clr.clamp_cnt_hold", int'(clamp_cnt), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
